// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, the data widths and the default reset PC.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs with push, pop, flush and an occupancy count.
// The head is forced to zero while empty so that idle outputs are deterministic.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [XLEN-1:0]        push_pc_i,
    input  logic [ILEN-1:0]        push_instr_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    output logic [XLEN-1:0]        head_pc_o,
    output logic [ILEN-1:0]        head_instr_o,
    output logic [$clog2(QDEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(QDEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [XLEN-1:0] pc_mem_q    [QDEPTH];
    logic [ILEN-1:0] instr_mem_q [QDEPTH];
    logic            do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && valid_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign valid_o      = (count_q != '0);
    assign head_pc_o    = valid_o ? pc_mem_q[rd_ptr_q]    : '0;
    assign head_instr_o = valid_o ? instr_mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect/flush handling and a
// small decoupling queue towards decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [ILEN-1:0] imem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occ_next;
    logic            ack_kept, pop, issue;

    assign ack_kept = imem_ack_i && (state_q == ST_WAIT) && !redirect_i;
    assign pop      = instr_valid_o && instr_ready_i && !redirect_i;
    // Occupancy after this cycle's enqueue/dequeue; a new request must still fit.
    assign occ_next = {1'b0, count} + (CW+1)'(ack_kept) - (CW+1)'(pop);

    always_comb begin
        issue = 1'b0;
        if (!rst_i && !redirect_i && (occ_next < (CW+1)'(QDEPTH))) begin
            if (state_q == ST_IDLE)                    issue = 1'b1;
            else if (state_q == ST_WAIT && imem_ack_i) issue = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        if (redirect_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_pc_d   = fetch_pc_q;
        end
        unique case (state_q)
            ST_IDLE: if (issue) state_d = ST_WAIT;
            ST_WAIT: begin
                if (redirect_i)                 state_d = imem_ack_i ? ST_IDLE : ST_DROP;
                else if (imem_ack_i && !issue)  state_d = ST_IDLE;
            end
            ST_DROP: if (imem_ack_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= word_align(RESET_PC);
            tag_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
        end
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc_q;
    assign pc_plus4_o  = pc_o + 32'd4;

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ack_kept),
        .push_pc_i   (tag_pc_q),
        .push_instr_i(imem_data_i),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .valid_o     (instr_valid_o),
        .head_pc_o   (pc_o),
        .head_instr_o(instr_o),
        .count_o     (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests and
// instructions (with relative cycle numbers); a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_ready_i;

    typedef struct { int c; logic [31:0] a; } exp_t;
    typedef struct { int due; logic [31:0] a; } pend_t;

    exp_t  exp_req[$];
    exp_t  exp_ins[$];
    pend_t pend[$];

    int cyc    = 0;
    int t0     = 0;
    int lat    = 1;
    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc - t0, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc - t0, act, exp);
        end
    endtask

    task automatic er(input int c, input logic [31:0] a);
        exp_req.push_back('{c, a});
    endtask

    task automatic ei(input int c, input logic [31:0] pc);
        exp_ins.push_back('{c, pc});
    endtask

    // Memory model: ack exactly lat cycles after each observed request.
    initial begin
        pend_t p;
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            imem_ack_i  = 1'b0;
            imem_data_i = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                imem_ack_i  = 1'b1;
                imem_data_i = mem_word(p.a);
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (imem_req_o === 1'b1) pend.push_back('{cyc + lat, imem_addr_o});
    end

    // Scoreboard monitor.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk_i);
            if (imem_req_o === 1'b1) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected at cycle %0d: got addr %h want no request", cyc - t0, imem_addr_o);
                end else begin
                    r = exp_req.pop_front();
                    chk_int("req_cycle", cyc - t0, r.c);
                    chk32("req_addr", imem_addr_o, r.a);
                end
            end
            if (instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
                if (exp_ins.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_unexpected at cycle %0d: got pc %h want no instruction", cyc - t0, pc_o);
                end else begin
                    r = exp_ins.pop_front();
                    chk_int("instr_cycle", cyc - t0, r.c);
                    chk32("pc", pc_o, r.a);
                    chk32("instr", instr_o, mem_word(r.a));
                    chk32("pc_plus4", pc_plus4_o, r.a + 32'd4);
                end
            end
        end
    end

    task automatic goto(input int rel);
        while (cyc - t0 < rel) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk32("rst_req", {31'b0, imem_req_o}, 32'd0);
            chk32("rst_valid", {31'b0, instr_valid_o}, 32'd0);
            chk32("rst_instr", instr_o, 32'd0);
            chk32("rst_pc", pc_o, 32'd0);
            chk32("rst_pc_plus4", pc_plus4_o, 32'd4);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start(input int l, input logic rdy);
        lat           = l;
        instr_ready_i = rdy;
        redirect_i    = 1'b0;
        rst_i         = 1'b0;
        t0            = cyc;
    endtask

    task automatic finish_scn(input int hold);
        rst_i = 1'b1;
        chk_int("left_req", exp_req.size(), 0);
        chk_int("left_instr", exp_ins.size(), 0);
        exp_req.delete();
        exp_ins.delete();
        hold_reset(hold);
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        hold_reset(3);

        // Streaming at one instruction per cycle.
        er(0, 32'h0); er(1, 32'h4); er(2, 32'h8); er(3, 32'hC); er(4, 32'h10); er(5, 32'h14);
        ei(2, 32'h0); ei(3, 32'h4); ei(4, 32'h8); ei(5, 32'hC);
        start(1, 1'b1);
        goto(6);
        finish_scn(2);

        // Backpressure: queue fills after QDEPTH requests, resumes on ready.
        er(0, 32'h0); er(1, 32'h4); er(6, 32'h8); er(7, 32'hC); er(8, 32'h10);
        ei(6, 32'h0); ei(7, 32'h4); ei(8, 32'h8);
        start(1, 1'b0);
        goto(6);
        instr_ready_i = 1'b1;
        goto(9);
        finish_scn(2);

        // Redirect while outstanding; stale ack must be dropped.
        er(0, 32'h0); er(3, 32'h4); er(7, 32'h100); er(10, 32'h104); er(13, 32'h108);
        ei(11, 32'h100); ei(14, 32'h104);
        start(3, 1'b0);
        goto(3);
        @(negedge clk_i);
        chk32("pre_flush_valid", {31'b0, instr_valid_o}, 32'd0);
        goto(4);
        @(negedge clk_i);
        chk32("pre_redirect_valid", {31'b0, instr_valid_o}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        goto(5);
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        chk32("flush_valid", {31'b0, instr_valid_o}, 32'd0);
        goto(15);
        finish_scn(2);

        // Redirect coincident with ack.
        er(0, 32'h0); er(3, 32'h2000); er(5, 32'h2004); er(7, 32'h2008);
        ei(6, 32'h2000); ei(8, 32'h2004);
        start(2, 1'b1);
        goto(2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        goto(3);
        redirect_i = 1'b0;
        goto(9);
        finish_scn(2);

        // Address wrap at the top of memory; redirect low bits ignored.
        er(1, 32'hFFFF_FFF8); er(2, 32'hFFFF_FFFC); er(3, 32'h0); er(4, 32'h4); er(5, 32'h8);
        ei(3, 32'hFFFF_FFF8); ei(4, 32'hFFFF_FFFC); ei(5, 32'h0);
        start(1, 1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF9;
        goto(1);
        redirect_i = 1'b0;
        goto(6);
        finish_scn(2);

        // Reset mid-WAIT; its ack lands during reset and must vanish.
        er(0, 32'h0);
        start(3, 1'b1);
        goto(1);
        finish_scn(3);

        er(0, 32'h0); er(1, 32'h4); er(2, 32'h8); er(3, 32'hC);
        ei(2, 32'h0); ei(3, 32'h4);
        start(1, 1'b1);
        goto(4);
        finish_scn(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
